// File: rtl/duck_sprite_reader.sv
// Duck sprite ROM read client: maps DrawX/DrawY onto the sprite box, drives the ROM address,
// applies colour-key transparency and cycles animation frames. Define DUCK_MIRROR_EN for horizontal flip.
module duck_sprite_reader #(
  parameter int          SPR_W      = 20,
  parameter int          SPR_H      = 19,
  parameter int          NUM_FRAMES = 3,
  parameter int          FRAME_HOLD = 8,
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_show,
  input  logic        anim_run,
  input  logic        facing_left,
  output logic [18:0] read_address,
  input  logic [23:0] rom_data,
  output logic [23:0] pixel_color,
  output logic        pixel_on
);

  localparam int          HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int          IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [18:0] FRAME_STEP = 19'(SPR_W * SPR_H);

  logic [9:0]        sx_reg, sy_reg;
  logic              show_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [IDX_W-1:0]  frame_idx_reg;
  logic [18:0]       frame_base_reg;
  logic [18:0]       read_address_reg, read_address_next;
  logic              hit_q1_reg, hit_q2_reg, hit_next;
  logic              pixel_on_reg, pixel_on_next;
  logic [23:0]       pixel_color_reg, pixel_color_next;
  logic              mirror;

  // Position is only sampled on frame_start so the sprite never tears mid-frame
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx_reg   <= '0;
      sy_reg   <= '0;
      show_reg <= 1'b0;
    end else if (frame_start) begin
      sx_reg   <= sprite_x;
      sy_reg   <= sprite_y;
      show_reg <= sprite_show;
    end
  end

`ifdef DUCK_MIRROR_EN
  logic facing_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      facing_reg <= 1'b0;
    end else if (frame_start) begin
      facing_reg <= facing_left;
    end
  end

  assign mirror = facing_reg;
`else
  logic unused_facing;

  assign unused_facing = facing_left;
  assign mirror        = 1'b0;
`endif

  // Frame base advances by one sprite's worth of words, avoiding a multiplier
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt_reg   <= '0;
      frame_idx_reg  <= '0;
      frame_base_reg <= '0;
    end else if (frame_start) begin
      if (anim_run) begin
        if (hold_cnt_reg == HOLD_W'(FRAME_HOLD - 1)) begin
          hold_cnt_reg <= '0;
          if (frame_idx_reg == IDX_W'(NUM_FRAMES - 1)) begin
            frame_idx_reg  <= '0;
            frame_base_reg <= '0;
          end else begin
            frame_idx_reg  <= frame_idx_reg + IDX_W'(1);
            frame_base_reg <= frame_base_reg + FRAME_STEP;
          end
        end else begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
      end else begin
        hold_cnt_reg <= '0;
      end
    end
  end

  logic [10:0] x_end, y_end;
  logic [9:0]  col_raw, col, row;
  logic        in_x, in_y;

  // 11-bit box edges so a sprite near the right/bottom edge never wraps
  always_comb begin
    x_end   = {1'b0, sx_reg} + 11'(SPR_W);
    y_end   = {1'b0, sy_reg} + 11'(SPR_H);
    in_x    = (DrawX >= sx_reg) && ({1'b0, DrawX} < x_end);
    in_y    = (DrawY >= sy_reg) && ({1'b0, DrawY} < y_end);
    hit_next = show_reg && in_x && in_y;
    col_raw = DrawX - sx_reg;
    row     = DrawY - sy_reg;
    col     = mirror ? (10'(SPR_W - 1) - col_raw) : col_raw;
    read_address_next = '0;
    if (hit_next) begin
      read_address_next = frame_base_reg + 19'(row) * 19'(SPR_W) + 19'(col);
    end
  end

  always_comb begin
    pixel_on_next    = hit_q2_reg && (rom_data != TRANSP_KEY);
    pixel_color_next = pixel_on_next ? rom_data : 24'h0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address_reg <= '0;
      hit_q1_reg       <= 1'b0;
      hit_q2_reg       <= 1'b0;
      pixel_on_reg     <= 1'b0;
      pixel_color_reg  <= '0;
    end else begin
      read_address_reg <= read_address_next;
      hit_q1_reg       <= hit_next;
      hit_q2_reg       <= hit_q1_reg;
      pixel_on_reg     <= pixel_on_next;
      pixel_color_reg  <= pixel_color_next;
    end
  end

  assign read_address = read_address_reg;
  assign pixel_on     = pixel_on_reg;
  assign pixel_color  = pixel_color_reg;

endmodule

// File: doc/duck_sprite_reader.md
Name: duck_sprite_reader

Overview:
- Read-side client of the 1140-word x 24-bit synchronous duck sprite ROM; the ROM registers its data one clock after the address.
- Maps VGA DrawX/DrawY onto the sprite's bounding box and generates read_address.
- Pipelines the in-box flag across the ROM latency, applies colour-key transparency, and steps through animation frames on frame boundaries.
- Sits between the VGA controller / duck motion logic and the colour mapper.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 19, sprite height in pixels
- NUM_FRAMES, 3, animation frames stored back-to-back in the ROM (3*20*19 = 1140 words)
- FRAME_HOLD, 8, video frames each animation frame is displayed
- TRANSP_KEY, 24'hFF00FF, ROM colour treated as transparent

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each video frame
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- sprite_x  in  10  sprite top-left column, live value
- sprite_y  in  10  sprite top-left row, live value
- sprite_show  in  1  sprite visible, live value
- anim_run  in  1  advance the animation when high
- facing_left  in  1  mirror request; ignored unless DUCK_MIRROR_EN is defined
- read_address  out  19  address to the sprite ROM
- rom_data  in  24  ROM data, valid one clock after read_address
- pixel_color  out  24  sprite RGB, 0 when pixel_on = 0
- pixel_on  out  1  opaque sprite pixel at this position

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0. Latched position 0, latched show 0, frame_idx 0, hold_cnt 0, frame_base 0, pipeline valid bits 0.
- Position latch: sprite_x, sprite_y and sprite_show are captured into sx/sy/show only on clocks where frame_start = 1. Changes between pulses have no effect (prevents tearing).
- Stage 1, registered at edge E+1 from DrawX/DrawY at edge E:
  - hit = show && DrawX >= sx && DrawX < sx+SPR_W && DrawY >= sy && DrawY < sy+SPR_H.
  - Comparisons use 11-bit sums so sx+SPR_W never wraps; a box clipped at the screen edge simply yields no hits beyond it.
  - col = DrawX - sx, row = DrawY - sy.
  - read_address = frame_base + row*SPR_W + col when hit, otherwise 0.
  - hit_q1 = hit.
- Stage 2: the ROM returns data during the cycle after read_address. hit_q2 <= hit_q1.
- Stage 3, registered:
  - pixel_on <= hit_q2 && (rom_data != TRANSP_KEY).
  - pixel_color <= rom_data when pixel_on would be 1, else 0.
- Latency: fixed 3 clocks from DrawX/DrawY to pixel_on/pixel_color. The pipeline is free-running every clock, with no stall. The caller delays DrawX/DrawY or sync signals to match.
- Animation:
  - Runs only on clocks with frame_start = 1 and anim_run = 1.
  - hold_cnt counts 0..FRAME_HOLD-1.
  - When hold_cnt = FRAME_HOLD-1: hold_cnt returns to 0 and frame_idx increments. frame_base += SPR_W*SPR_H, computed incrementally with no multiplier.
  - frame_idx wraps NUM_FRAMES-1 -> 0 with frame_base -> 0.
  - anim_run = 0 at frame_start: hold_cnt cleared, frame_idx and frame_base held.
- Simultaneous events: the position latch and animation step on the same frame_start edge both take effect. Stage-1 addressing uses the new frame_base from the next clock on.
- Reset mid-frame: outputs go to 0 immediately (asynchronous). In-flight pipeline data is discarded. No sprite is shown until the next frame_start latches show = 1.

Optional Feature:
- Macro: DUCK_MIRROR_EN.
- Defined: facing_left is latched alongside the position on frame_start. When the latched value is 1, col = SPR_W-1-(DrawX-sx) (horizontal mirror). Latency unchanged.
- Undefined: facing_left is ignored, no flip logic is built, and col = DrawX-sx always.

Test Plan:
- Reset asserted mid-run -> read_address = 0, pixel_on = 0, pixel_color = 0 the same cycle; after release, no pixel_on until a frame_start with sprite_show = 1.
- sprite_x=100, sprite_y=50, show=1, frame_start pulse, then DrawX=105, DrawY=52 -> read_address = 45 one clock later; with ROM model word 45 = 24'h8B4513, pixel_on = 1 and pixel_color = 24'h8B4513 three clocks after the DrawX/DrawY input.
- DrawX=120, DrawY=52 (col 20, outside box) -> read_address = 0, pixel_on = 0. Changing sprite_x to 200 without frame_start -> the hit at DrawX=105 persists.
- ROM word equal to 24'hFF00FF at an in-box pixel -> pixel_on = 0, pixel_color = 0.
- anim_run=1 for 8 frame_start pulses -> same pixel (105,52) reads address 425. After 24 pulses total it wraps to 45. Dropping anim_run at pulse 4, then restarting -> frame change after 8 more pulses.
- DUCK_MIRROR_EN defined, facing_left=1 latched, DrawX=105, DrawY=52 -> read_address = 54. Without the macro -> 45.
